// File: rtl/calc_result_display_if.sv
// Result bus and seven-segment display signals between the calculator core and the display stage.
interface calc_result_display_if;
    logic [7:0] result_in;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic       busy;
    logic       done;

    modport master (output result_in, input hex0, hex1, hex2, hex3, busy, done);
    modport slave  (input result_in, output hex0, hex1, hex2, hex3, busy, done);
endinterface

// File: rtl/calc_result_display.sv
// Glitch-filtered binary-to-BCD (double-dabble, 1 bit/clock) seven-segment display with leading-zero blanking.
// Define CALC_SIGNED_DISPLAY_EN to treat result_in as two's complement and show a minus sign on hex3.
module calc_result_display #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    calc_result_display_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, UPDATE} state_t;

    localparam logic [4:0] STABLE_LIM = 5'(STABLE_CYCLES);
    localparam logic [6:0] POL        = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [6:0] SEG_BLANK  = 7'h7F ^ POL;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s ^ POL;
    endfunction

    state_t      state;
    state_t      state_next;
    logic [7:0]  sample_q;
    logic [7:0]  shown_q;
    logic [3:0]  cnt;
    logic        rearm;
    logic [2:0]  bit_cnt;
    logic [19:0] shreg;
    logic [19:0] shreg_adj;
    logic [6:0]  hex0_q;
    logic [6:0]  hex1_q;
    logic [6:0]  hex2_q;
    logic        done_q;
    logic        stable;
    logic        count_hit;
    logic        start;
    logic [4:0]  cnt_inc;
    logic [7:0]  magnitude;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  units;

    assign stable    = (bus.result_in == sample_q);
    assign cnt_inc   = {1'b0, cnt} + 5'd1;
    assign count_hit = (cnt_inc >= STABLE_LIM);
    assign start     = ((state == IDLE) || (state == SETTLE)) && !rearm && stable
                       && count_hit && (sample_q != shown_q);

    assign hund  = shreg[19:16];
    assign tens  = shreg[15:12];
    assign units = shreg[11:8];

`ifdef CALC_SIGNED_DISPLAY_EN
    localparam logic [6:0] SEG_MINUS = 7'h3F ^ POL;
    logic [6:0] hex3_q;
    logic       neg_q;

    assign magnitude = sample_q[7] ? (~sample_q + 8'd1) : sample_q;
    assign bus.hex3  = hex3_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            neg_q  <= 1'b0;
            hex3_q <= SEG_BLANK;
        end else if (start) begin
            neg_q <= sample_q[7];
        end else if (state == UPDATE) begin
            hex3_q <= neg_q ? SEG_MINUS : SEG_BLANK;
        end
    end
`else
    assign magnitude = sample_q;
    assign bus.hex3  = SEG_BLANK;
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, SETTLE: begin
                if (!stable)        state_next = SETTLE;
                else if (start)     state_next = CONVERT;
                else if (count_hit) state_next = IDLE;
            end
            CONVERT: if (bit_cnt == 3'd7) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CONVERT) || (state == UPDATE);
    end

    always_comb begin
        shreg_adj = shreg;
        for (int unsigned i = 0; i < 3; i++) begin
            if (shreg[8 + 4*i +: 4] >= 4'd5) shreg_adj[8 + 4*i +: 4] = shreg[8 + 4*i +: 4] + 4'd3;
        end
    end

    // rearm makes the first IDLE edge after UPDATE behave like a fresh first
    // sample, so the filter window restarts cleanly after every conversion.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sample_q <= '0;
            shown_q  <= '0;
            cnt      <= '0;
            rearm    <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            hex0_q   <= seg7(4'd0);
            hex1_q   <= SEG_BLANK;
            hex2_q   <= SEG_BLANK;
            done_q   <= 1'b0;
        end else begin
            sample_q <= bus.result_in;
            done_q   <= 1'b0;
            case (state)
                IDLE, SETTLE: begin
                    rearm <= 1'b0;
                    if (rearm || !stable) cnt <= '0;
                    else if (!count_hit)  cnt <= cnt + 4'd1;
                    if (start) begin
                        shown_q <= sample_q;
                        shreg   <= {12'h000, magnitude};
                        bit_cnt <= '0;
                    end
                end
                CONVERT: begin
                    cnt     <= '0;
                    shreg   <= shreg_adj << 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                UPDATE: begin
                    cnt    <= '0;
                    rearm  <= 1'b1;
                    done_q <= 1'b1;
                    hex0_q <= seg7(units);
                    hex1_q <= ((hund == 4'd0) && (tens == 4'd0)) ? SEG_BLANK : seg7(tens);
                    hex2_q <= (hund == 4'd0) ? SEG_BLANK : seg7(hund);
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.hex0 = hex0_q;
    assign bus.hex1 = hex1_q;
    assign bus.hex2 = hex2_q;
    assign bus.done = done_q;
endmodule
